hazard_scoreboard: RTL and testbench

- Sequencing controller for the instruction-decode stage of the 5-stage MIPS pipeline.
- Tracks destination registers of instructions in flight in EXE, MEM and WB with a 3-slot shadow pipeline.
- Compares them against the Rs/Rt of the instruction in ID and drives `hazard_detected` into the decode controller, plus PC/IF-ID freeze and IF flush.
- Supports forwarding-enabled (load-use stall only) and forwarding-disabled (full RAW stall) modes, and keeps a saturating stall counter.

---
 rtl/hazard_scoreboard_pkg.sv | 15 +
 rtl/hazard_scoreboard_slot.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 116 +++++++++++
 tb/tb_hazard_scoreboard.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard.
//   REG_FILE_ADDR_LEN : register-file address width (default REG_ADDR_W)
//   STALL_CNT_LEN     : stall statistics counter width (default STALL_CNT_W)
//   NUM_SLOTS / SLOT_*: shadow pipeline depth and slot positions
package hazard_scoreboard_pkg;

    localparam int REG_FILE_ADDR_LEN = 5;
    localparam int STALL_CNT_LEN     = 16;

    localparam int NUM_SLOTS = 3;
    localparam int SLOT_EX   = 0;
    localparam int SLOT_MEM  = 1;
    localparam int SLOT_WB   = 2;

endpackage

// File: rtl/hazard_scoreboard_slot.sv
// One entry of the shadow pipeline: a registered {valid, dest, load} triple.
// Ports:
//   clk, rst      : clock, asynchronous active-low clear
//   i_hold        : 1 = keep current contents (global pipeline freeze)
//   i_valid/i_dest/i_load : value shifted in on the next rising edge
//   o_valid/o_dest/o_load : current slot contents
module scoreboard_slot
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_FILE_ADDR_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_hold,
    input  logic                  i_valid,
    input  logic [REG_ADDR_W-1:0] i_dest,
    input  logic                  i_load,
    output logic                  o_valid,
    output logic [REG_ADDR_W-1:0] o_dest,
    output logic                  o_load
);

    logic                  r_valid;
    logic [REG_ADDR_W-1:0] r_dest;
    logic                  r_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_dest  <= '0;
            r_load  <= 1'b0;
        end else if (!i_hold) begin
            r_valid <= i_valid;
            r_dest  <= i_dest;
            r_load  <= i_load;
        end
    end

    assign o_valid = r_valid;
    assign o_dest  = r_dest;
    assign o_load  = r_load;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the ID stage of a 5-stage MIPS pipeline.
// Shadows the destination registers of instructions in EX/MEM/WB and compares
// them with the Rs/Rt of the ID instruction to request a bubble.
// Ports:
//   clk, rst (async active-low), fwd_en, pipe_freeze
//   id_rs, id_rt, id_uses_rt, id_wb_en, id_mem_read, id_dest, branch_taken
//   hazard_detected, pc_freeze, ifid_freeze, if_flush : combinational outputs
//   stall_count : saturating count of non-frozen stall cycles
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_FILE_ADDR_LEN,
    parameter int STALL_CNT_W = STALL_CNT_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fwd_en,
    input  logic                   pipe_freeze,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rt,
    input  logic                   id_wb_en,
    input  logic                   id_mem_read,
    input  logic [REG_ADDR_W-1:0]  id_dest,
    input  logic                   branch_taken,
    output logic                   hazard_detected,
    output logic                   pc_freeze,
    output logic                   ifid_freeze,
    output logic                   if_flush,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [NUM_SLOTS-1:0]  w_valid;
    logic [NUM_SLOTS-1:0]  w_load;
    logic [REG_ADDR_W-1:0] w_dest [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  w_in_valid;
    logic [NUM_SLOTS-1:0]  w_in_load;
    logic [REG_ADDR_W-1:0] w_in_dest [NUM_SLOTS];

    logic w_hazard;
    logic w_hit_ex;
    logic w_hit_mem;

    logic [STALL_CNT_W-1:0] r_stall_count;

    // Register 0 is hard-wired to zero, so it never carries a dependency.
    function automatic logic reg_match(input logic                  v,
                                       input logic [REG_ADDR_W-1:0] d,
                                       input logic [REG_ADDR_W-1:0] r);
        return v & (r != '0) & (d == r);
    endfunction

    function automatic logic src_hit(input logic                  v,
                                     input logic [REG_ADDR_W-1:0] d);
        return reg_match(v, d, id_rs) | (id_uses_rt & reg_match(v, d, id_rt));
    endfunction

    // Shadow pipeline: EX is fed from ID (bubbled when stalling), the others
    // shift from the slot ahead of them.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            if (gi == SLOT_EX) begin : g_head
                assign w_in_valid[gi] = id_wb_en & ~w_hazard & (id_dest != '0);
                assign w_in_dest[gi]  = id_dest;
                assign w_in_load[gi]  = id_mem_read & ~w_hazard;
            end else begin : g_tail
                assign w_in_valid[gi] = w_valid[gi-1];
                assign w_in_dest[gi]  = w_dest[gi-1];
                assign w_in_load[gi]  = w_load[gi-1];
            end

            scoreboard_slot #(
                .REG_ADDR_W(REG_ADDR_W)
            ) u_slot (
                .clk     (clk),
                .rst     (rst),
                .i_hold  (pipe_freeze),
                .i_valid (w_in_valid[gi]),
                .i_dest  (w_in_dest[gi]),
                .i_load  (w_in_load[gi]),
                .o_valid (w_valid[gi]),
                .o_dest  (w_dest[gi]),
                .o_load  (w_load[gi])
            );
        end
    endgenerate

    assign w_hit_ex  = src_hit(w_valid[SLOT_EX],  w_dest[SLOT_EX]);
    assign w_hit_mem = src_hit(w_valid[SLOT_MEM], w_dest[SLOT_MEM]);

    // WB never stalls: the register file writes in the first half-cycle and
    // reads in the second. The slot is kept so the shadow mirrors the pipe.
    logic w_wb_unused;
    assign w_wb_unused = ^{w_valid[SLOT_WB], w_dest[SLOT_WB], w_load[SLOT_WB]};

    // With forwarding only a load in EX cannot deliver its data in time.
    assign w_hazard = fwd_en ? (w_load[SLOT_EX] & w_hit_ex)
                             : (w_hit_ex | w_hit_mem);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= '0;
        end else if (w_hazard && !pipe_freeze &&
                     (r_stall_count != {STALL_CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign hazard_detected = w_hazard;
    assign pc_freeze       = w_hazard;
    assign ifid_freeze     = w_hazard;
    // A branch evaluated on stale operands is not resolved yet.
    assign if_flush        = branch_taken & ~w_hazard;
    assign stall_count     = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        fwd_en, pipe_freeze;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_uses_rt, id_wb_en, id_mem_read, branch_taken;
    logic        hazard_detected, pc_freeze, ifid_freeze, if_flush;
    logic [15:0] stall_count;
    logic        s_hazard, s_pcf, s_ifidf, s_flush;
    logic [3:0]  s_count;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .pipe_freeze(pipe_freeze),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .branch_taken(branch_taken), .hazard_detected(hazard_detected),
        .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze),
        .if_flush(if_flush), .stall_count(stall_count)
    );

    // Narrow-counter instance: same stimulus, used to reach saturation quickly.
    hazard_scoreboard #(.REG_ADDR_W(5), .STALL_CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .pipe_freeze(pipe_freeze),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .branch_taken(branch_taken), .hazard_detected(s_hazard),
        .pc_freeze(s_pcf), .ifid_freeze(s_ifidf),
        .if_flush(s_flush), .stall_count(s_count)
    );

    typedef struct {
        logic        haz;
        logic        flush;
        logic [15:0] cnt;
        logic [3:0]  scnt;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic eh, input logic ef, input string tag);
        exp_t e;
        e.haz   = eh;
        e.flush = ef;
        e.cnt   = exp_cnt[15:0];
        e.scnt  = (exp_cnt >= 15) ? 4'hF : exp_cnt[3:0];
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic check_outputs();
        exp_t e;
        e = exp_q.pop_front();
        chk({e.tag, ".hazard"},  {31'd0, hazard_detected}, {31'd0, e.haz});
        chk({e.tag, ".pcf"},     {31'd0, pc_freeze},       {31'd0, e.haz});
        chk({e.tag, ".ifidf"},   {31'd0, ifid_freeze},     {31'd0, e.haz});
        chk({e.tag, ".flush"},   {31'd0, if_flush},        {31'd0, e.flush});
        chk({e.tag, ".count"},   {16'd0, stall_count},     {16'd0, e.cnt});
        chk({e.tag, ".s_haz"},   {31'd0, s_hazard},        {31'd0, e.haz});
        chk({e.tag, ".s_count"}, {28'd0, s_count},         {28'd0, e.scnt});
        $display("cyc %-10s fwd=%0b frz=%0b rs=%0d rt=%0d urt=%0b wb=%0b ld=%0b dst=%0d br=%0b -> haz=%0b flush=%0b cnt=%0d scnt=%0d",
                 e.tag, fwd_en, pipe_freeze, id_rs, id_rt, id_uses_rt, id_wb_en,
                 id_mem_read, id_dest, branch_taken, hazard_detected, if_flush,
                 stall_count, s_count);
    endtask

    // Drive one ID cycle (just after a rising edge), check outputs on the
    // falling edge, then advance past the next rising edge.
    task automatic cyc(input logic fe, input logic pf, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic wb,
                       input logic mr, input logic [4:0] dst, input logic br,
                       input logic eh, input logic ef, input string tag);
        fwd_en = fe; pipe_freeze = pf; id_rs = rs; id_rt = rt;
        id_uses_rt = urt; id_wb_en = wb; id_mem_read = mr; id_dest = dst;
        branch_taken = br;
        push_exp(eh, ef, tag);
        @(negedge clk);
        check_outputs();
        if (eh && !pf) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic fe, input int n);
        for (int i = 0; i < n; i++)
            cyc(fe, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, "idle");
    endtask

    initial begin
        rst = 1'b1;
        fwd_en = 0; pipe_freeze = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        id_wb_en = 0; id_mem_read = 0; id_dest = 0; branch_taken = 0;
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset held with random ID fields
        for (int i = 0; i < 2; i++)
            cyc(0, 0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 5'($urandom), 0, 0, 0, "rst");
        rst = 1'b1;
        // Idle stream with no writers never stalls
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 5'($urandom), 5'($urandom), 1, 0, 0, 5'($urandom), 0, 0, 0, "nowb");

        // RAW without forwarding: add r3 then reader of r3 -> 2 stalls
        cyc(0, 0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 0, 0, "raw_prod");
        cyc(0, 0, 5'd3, 5'd0, 0, 1, 0, 5'd4, 0, 1, 0, "raw_ex");
        cyc(0, 0, 5'd3, 5'd0, 0, 1, 0, 5'd4, 0, 1, 0, "raw_mem");
        cyc(0, 0, 5'd3, 5'd0, 0, 1, 0, 5'd4, 0, 0, 0, "raw_go");
        chk("raw_count", {16'd0, stall_count}, 32'd2);
        idle(0, 3);

        // Load-use with forwarding -> exactly 1 stall
        cyc(1, 0, 5'd0, 5'd0, 0, 1, 1, 5'd5, 0, 0, 0, "lw_prod");
        cyc(1, 0, 5'd0, 5'd5, 1, 1, 0, 5'd6, 0, 1, 0, "lw_use");
        cyc(1, 0, 5'd0, 5'd5, 1, 1, 0, 5'd6, 0, 0, 0, "lw_go");
        idle(1, 3);
        // ALU producer with forwarding -> no stall
        cyc(1, 0, 5'd0, 5'd0, 0, 1, 0, 5'd5, 0, 0, 0, "add_prod");
        cyc(1, 0, 5'd0, 5'd5, 1, 0, 0, 5'd0, 0, 0, 0, "add_use");
        idle(1, 3);
        chk("fwd_count", {16'd0, stall_count}, 32'd3);

        // Register zero and immediate forms
        cyc(0, 0, 5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 0, 0, "r0_prod");
        cyc(0, 0, 5'd0, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0, "r0_use");
        idle(0, 3);
        cyc(0, 0, 5'd0, 5'd0, 0, 1, 0, 5'd7, 0, 0, 0, "imm_prod");
        cyc(0, 0, 5'd1, 5'd7, 0, 0, 0, 5'd0, 0, 0, 0, "imm_use");
        cyc(0, 0, 5'd1, 5'd7, 1, 0, 0, 5'd0, 0, 1, 0, "rt_use");
        idle(0, 3);

        // Branch with and without a pending hazard
        cyc(0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 1, "br_clean");
        cyc(0, 0, 5'd0, 5'd0, 0, 1, 0, 5'd9, 0, 0, 0, "br_prod");
        cyc(0, 0, 5'd9, 5'd0, 1, 0, 0, 5'd0, 1, 1, 0, "br_haz_ex");
        cyc(0, 0, 5'd9, 5'd0, 1, 0, 0, 5'd0, 1, 1, 0, "br_haz_mem");
        cyc(0, 0, 5'd9, 5'd0, 1, 0, 0, 5'd0, 1, 0, 1, "br_go");
        idle(0, 3);

        // Freeze during a hazard: state and counter hold
        cyc(0, 0, 5'd0, 5'd0, 0, 1, 0, 5'd10, 0, 0, 0, "frz_prod");
        cyc(0, 1, 5'd10, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, "frz_1");
        cyc(0, 1, 5'd10, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, "frz_2");
        chk("frz_count", {16'd0, stall_count}, 32'd6);
        cyc(0, 0, 5'd10, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, "frz_ex");
        cyc(0, 0, 5'd10, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, "frz_mem");
        cyc(0, 0, 5'd10, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, "frz_go");
        idle(0, 3);

        // fwd_en toggled mid-stream acts immediately on the same state
        cyc(0, 0, 5'd0, 5'd0, 0, 1, 0, 5'd11, 0, 0, 0, "mode_prod");
        cyc(1, 0, 5'd11, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, "mode_fwd");
        cyc(0, 0, 5'd11, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, "mode_nofwd");
        idle(0, 3);
        chk("pre_rst_count", {16'd0, stall_count}, 32'd9);

        // Reset in the middle of a stall
        cyc(0, 0, 5'd0, 5'd0, 0, 1, 0, 5'd12, 0, 0, 0, "mrst_prod");
        id_rs = 5'd12; id_wb_en = 0; id_dest = 0;
        push_exp(1, 0, "mrst_haz");
        @(negedge clk);
        check_outputs();
        #2 rst = 1'b0;
        #1;
        chk("mrst_hazard", {31'd0, hazard_detected}, 32'd0);
        chk("mrst_count",  {16'd0, stall_count},     32'd0);
        chk("mrst_scount", {28'd0, s_count},         32'd0);
        exp_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        idle(0, 1);

        // Saturation on the 4-bit instance: 14 stalls, then 3 more
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 5'd0, 5'd0, 0, 1, 0, 5'd3, 0, 0, 0, "sat_prod");
            cyc(0, 0, 5'd3, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, "sat_ex");
            cyc(0, 0, 5'd3, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, "sat_mem");
        end
        chk("sat_preload", {28'd0, s_count}, 32'hE);
        cyc(0, 0, 5'd0, 5'd0, 0, 1, 0, 5'd3, 0, 0, 0, "sat_prod");
        cyc(0, 0, 5'd3, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, "sat_ex");
        cyc(0, 0, 5'd3, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, "sat_mem");
        cyc(0, 0, 5'd0, 5'd0, 0, 1, 0, 5'd3, 0, 0, 0, "sat_prod");
        cyc(0, 0, 5'd3, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, "sat_ex");
        idle(0, 3);
        chk("sat_full",  {28'd0, s_count},     32'hF);
        chk("wide_cnt",  {16'd0, stall_count}, 32'd17);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
